// File: rtl/fetch_decode_if.sv
// Bundle of fetch-side memory handshake, issue handshake to execute, and
// branch feedback from the ALU; master is the fetch/decode stage.
interface fetch_decode_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        issue_valid;
    logic        issue_ready;
    logic [6:0]  opcode;
    logic [3:0]  ra_idx;
    logic [3:0]  rb_idx;
    logic        highlow;
    logic [15:0] value;
    logic [31:0] pc_out;
    logic        addrch;
    logic [31:0] naddr;
    logic        halted;
    logic [31:0] instr_count;

    modport master (
        output mem_req, mem_addr, issue_valid, opcode, ra_idx, rb_idx,
               highlow, value, pc_out, halted, instr_count,
        input  mem_valid, mem_rdata, issue_ready, addrch, naddr
    );

    modport slave (
        input  mem_req, mem_addr, issue_valid, opcode, ra_idx, rb_idx,
               highlow, value, pc_out, halted, instr_count,
        output mem_valid, mem_rdata, issue_ready, addrch, naddr
    );
endinterface

// File: rtl/fetch_decode.sv
// Fetch/decode stage: fetches one word per request, holds it in IR, and
// offers its decoded fields to execute until accepted; branches redirect the PC.
module fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4,
    parameter logic [6:0]  HALT_OP  = 7'd127
) (
    input logic             clock,
    input logic             reset_n,
    fetch_decode_if.master  bus
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] count_q, count_d;
    logic        run_q;

    // run_q keeps mem_req low until the first edge after reset is released
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0;
            count_q <= 32'h0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            count_q <= count_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        count_d = count_q;
        case (state_q)
            FETCH: begin
                if (run_q && bus.mem_valid) begin
                    ir_d    = bus.mem_rdata;
                    state_d = (bus.mem_rdata[31:25] == HALT_OP) ? HALTED : ISSUE;
                end
            end
            ISSUE: begin
                if (bus.issue_ready) begin
                    count_d = count_q + 32'd1;
                    pc_d    = bus.addrch ? (bus.naddr & 32'hFFFF_FFFC)
                                         : (pc_q + 32'(PC_STEP));
                    state_d = FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign bus.mem_req     = run_q && (state_q == FETCH);
    assign bus.mem_addr    = pc_q;
    assign bus.issue_valid = (state_q == ISSUE);
    assign bus.halted      = (state_q == HALTED);
    assign bus.opcode      = ir_q[31:25];
    assign bus.ra_idx      = ir_q[24:21];
    assign bus.rb_idx      = ir_q[20:17];
    assign bus.highlow     = ir_q[16];
    assign bus.value       = ir_q[15:0];
    assign bus.pc_out      = pc_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: sequential fetch, backpressure, branch,
// PC wrap (second instance), async reset mid-fetch and halt.
module tb_fetch_decode;

    logic clock;
    logic reset_n;
    int   errors;
    int   checks;

    fetch_decode_if bus0 ();
    fetch_decode_if bus1 ();

    fetch_decode dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0.master)
    );

    fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus0.mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        bus0.mem_valid = 1'b0; bus0.mem_rdata = 32'h0; bus0.issue_ready = 1'b0;
        bus0.addrch = 1'b0; bus0.naddr = 32'h0;
        bus1.mem_valid = 1'b0; bus1.mem_rdata = 32'h0; bus1.issue_ready = 1'b0;
        bus1.addrch = 1'b0; bus1.naddr = 32'h0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (bus0.mem_req !== 1'b0 || bus0.issue_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshakes: req=%b valid=%b want 0 0", bus0.mem_req, bus0.issue_valid);
        end
        checks++;
        if (bus0.instr_count !== 32'h0 || bus0.mem_addr !== 32'h0 || bus0.halted !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_regs: count=%h addr=%h halted=%b want 0 0 0", bus0.instr_count, bus0.mem_addr, bus0.halted);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus0.mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release_req: got %b want 0", bus0.mem_req);
        end
        @(negedge clock);
        checks++;
        if (bus0.mem_req !== 1'b1 || bus0.mem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_first_req: req=%b addr=%h want 1 00000000", bus0.mem_req, bus0.mem_addr);
        end
    endtask

    task automatic test_sequential;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            wait_req(ok);
            checks++;
            if (!ok || bus0.mem_addr !== 32'(i * 4)) begin
                errors++;
                $display("[TB] FAIL seq_addr%0d: req=%b addr=%h want 1 %h", i, ok, bus0.mem_addr, 32'(i * 4));
            end
            bus0.mem_valid = 1'b1;
            bus0.mem_rdata = 32'h0046_1234;
            @(negedge clock);
            bus0.mem_valid = 1'b0;
            checks++;
            if (bus0.issue_valid !== 1'b1 || bus0.mem_req !== 1'b0 || bus0.opcode !== 7'd0 ||
                bus0.ra_idx !== 4'd2 || bus0.rb_idx !== 4'd3 || bus0.highlow !== 1'b0 ||
                bus0.value !== 16'h1234 || bus0.pc_out !== 32'(i * 4)) begin
                errors++;
                $display("[TB] FAIL seq_fields%0d: v=%b req=%b op=%h ra=%h rb=%h hl=%b val=%h pc=%h want 1 0 00 2 3 0 1234 %h",
                         i, bus0.issue_valid, bus0.mem_req, bus0.opcode, bus0.ra_idx, bus0.rb_idx,
                         bus0.highlow, bus0.value, bus0.pc_out, 32'(i * 4));
            end
            bus0.issue_ready = 1'b1;
            @(negedge clock);
            bus0.issue_ready = 1'b0;
            checks++;
            if (bus0.instr_count !== 32'(i + 1) || bus0.issue_valid !== 1'b0 || bus0.mem_req !== 1'b1) begin
                errors++;
                $display("[TB] FAIL seq_accept%0d: count=%0d v=%b req=%b want %0d 0 1",
                         i, bus0.instr_count, bus0.issue_valid, bus0.mem_req, i + 1);
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        wait_req(ok);
        checks++;
        if (!ok || bus0.mem_addr !== 32'd12) begin
            errors++;
            $display("[TB] FAIL bp_addr: req=%b addr=%h want 1 0000000c", ok, bus0.mem_addr);
        end
        bus0.mem_valid = 1'b1;
        bus0.mem_rdata = 32'h8B4B_BEEF;
        @(negedge clock);
        bus0.mem_rdata = 32'h1111_1111;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus0.issue_valid !== 1'b1 || bus0.mem_req !== 1'b0 || bus0.opcode !== 7'h45 ||
                bus0.ra_idx !== 4'hA || bus0.rb_idx !== 4'h5 || bus0.highlow !== 1'b1 ||
                bus0.value !== 16'hBEEF || bus0.pc_out !== 32'd12 || bus0.instr_count !== 32'd3) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: v=%b req=%b op=%h ra=%h rb=%h hl=%b val=%h pc=%h cnt=%0d want 1 0 45 a 5 1 beef c 3",
                         c, bus0.issue_valid, bus0.mem_req, bus0.opcode, bus0.ra_idx, bus0.rb_idx,
                         bus0.highlow, bus0.value, bus0.pc_out, bus0.instr_count);
            end
            @(negedge clock);
        end
        bus0.mem_valid = 1'b0;
        bus0.issue_ready = 1'b1;
        @(negedge clock);
        bus0.issue_ready = 1'b0;
        checks++;
        if (bus0.instr_count !== 32'd4 || bus0.mem_req !== 1'b1 || bus0.mem_addr !== 32'd16) begin
            errors++;
            $display("[TB] FAIL bp_accept: count=%0d req=%b addr=%h want 4 1 00000010",
                     bus0.instr_count, bus0.mem_req, bus0.mem_addr);
        end
    endtask

    task automatic test_branch;
        bit ok;
        wait_req(ok);
        bus0.addrch = 1'b1;
        bus0.naddr  = 32'h0000_0200;
        @(negedge clock);
        checks++;
        if (!ok || bus0.mem_req !== 1'b1 || bus0.mem_addr !== 32'd16) begin
            errors++;
            $display("[TB] FAIL br_fetch_ignore: req=%b addr=%h want 1 00000010", bus0.mem_req, bus0.mem_addr);
        end
        bus0.mem_valid = 1'b1;
        bus0.mem_rdata = 32'h0046_1234;
        @(negedge clock);
        bus0.mem_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (bus0.issue_valid !== 1'b1 || bus0.pc_out !== 32'd16) begin
            errors++;
            $display("[TB] FAIL br_issue_ignore: v=%b pc=%h want 1 00000010", bus0.issue_valid, bus0.pc_out);
        end
        bus0.naddr = 32'h0000_0103;
        bus0.issue_ready = 1'b1;
        @(negedge clock);
        bus0.issue_ready = 1'b0;
        bus0.addrch = 1'b0;
        bus0.naddr = 32'h0;
        checks++;
        if (bus0.mem_req !== 1'b1 || bus0.mem_addr !== 32'h0000_0100 || bus0.instr_count !== 32'd5) begin
            errors++;
            $display("[TB] FAIL br_target: req=%b addr=%h cnt=%0d want 1 00000100 5",
                     bus0.mem_req, bus0.mem_addr, bus0.instr_count);
        end
        bus0.mem_valid = 1'b1;
        @(negedge clock);
        bus0.mem_valid = 1'b0;
        bus0.issue_ready = 1'b1;
        @(negedge clock);
        bus0.issue_ready = 1'b0;
        checks++;
        if (bus0.mem_addr !== 32'h0000_0104 || bus0.instr_count !== 32'd6) begin
            errors++;
            $display("[TB] FAIL br_after: addr=%h cnt=%0d want 00000104 6", bus0.mem_addr, bus0.instr_count);
        end
    endtask

    task automatic test_wrap;
        checks++;
        if (bus1.mem_req !== 1'b1 || bus1.mem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("[TB] FAIL wrap_start: req=%b addr=%h want 1 fffffffc", bus1.mem_req, bus1.mem_addr);
        end
        bus1.mem_valid = 1'b1;
        bus1.mem_rdata = 32'h0046_1234;
        @(negedge clock);
        bus1.mem_valid = 1'b0;
        bus1.issue_ready = 1'b1;
        @(negedge clock);
        bus1.issue_ready = 1'b0;
        checks++;
        if (bus1.mem_req !== 1'b1 || bus1.mem_addr !== 32'h0 || bus1.instr_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL wrap_next: req=%b addr=%h cnt=%0d want 1 00000000 1",
                     bus1.mem_req, bus1.mem_addr, bus1.instr_count);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus0.mem_req !== 1'b0 || bus0.mem_addr !== 32'h0 || bus0.instr_count !== 32'h0 ||
            bus1.mem_addr !== 32'hFFFF_FFFC || bus1.instr_count !== 32'h0) begin
            errors++;
            $display("[TB] FAIL arst_immediate: req=%b addr=%h cnt=%0d wrapAddr=%h wrapCnt=%0d want 0 0 0 fffffffc 0",
                     bus0.mem_req, bus0.mem_addr, bus0.instr_count, bus1.mem_addr, bus1.instr_count);
        end
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (bus0.mem_req !== 1'b1 || bus0.mem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL arst_restart: req=%b addr=%h want 1 00000000", bus0.mem_req, bus0.mem_addr);
        end
    endtask

    task automatic test_halt;
        bit ok;
        wait_req(ok);
        bus0.mem_valid = 1'b1;
        bus0.mem_rdata = 32'h0046_1234;
        @(negedge clock);
        bus0.mem_valid = 1'b0;
        bus0.issue_ready = 1'b1;
        @(negedge clock);
        bus0.issue_ready = 1'b0;
        checks++;
        if (!ok || bus0.mem_addr !== 32'd4 || bus0.instr_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL halt_pre: addr=%h cnt=%0d want 00000004 1", bus0.mem_addr, bus0.instr_count);
        end
        bus0.mem_valid = 1'b1;
        bus0.mem_rdata = 32'hFE00_0042;
        @(negedge clock);
        bus0.issue_ready = 1'b1;
        bus0.mem_rdata = 32'h0046_1234;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (bus0.halted !== 1'b1 || bus0.issue_valid !== 1'b0 || bus0.mem_req !== 1'b0 ||
                bus0.instr_count !== 32'd1 || bus0.mem_addr !== 32'd4) begin
                errors++;
                $display("[TB] FAIL halt_hold%0d: halted=%b v=%b req=%b cnt=%0d addr=%h want 1 0 0 1 00000004",
                         c, bus0.halted, bus0.issue_valid, bus0.mem_req, bus0.instr_count, bus0.mem_addr);
            end
            @(negedge clock);
        end
        bus0.mem_valid = 1'b0;
        bus0.issue_ready = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch();
        test_wrap();
        test_async_reset();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
